// File: rtl/wb_regfile_pkg.sv
// Shared widths and constants for the write-back register file.
// Reset is active-low. Enables are active-high.
package wb_regfile_pkg;
  localparam int RegBusW     = 32;
  localparam int RegAddrBusW = 5;

  localparam logic [RegBusW-1:0]     ZeroWord   = '0;
  localparam logic [RegAddrBusW-1:0] NOPRegAddr = '0;

  localparam logic WriteEnable  = 1'b1;
  localparam logic WriteDisable = 1'b0;
  localparam logic ReadEnable   = 1'b1;
  localparam logic ReadDisable  = 1'b0;
  localparam logic RstEnable    = 1'b0;
endpackage : wb_regfile_pkg

// File: rtl/wb_regfile_if.sv
// Write-back stream in, ID/EX read ports out; no handshake, every write accepted.
interface wb_regfile_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] wb_wd;
  logic              wb_wreg;
  logic [DATA_W-1:0] wb_wdata;
  logic              wb_whilo;
  logic [DATA_W-1:0] wb_hi;
  logic [DATA_W-1:0] wb_lo;
  logic              re1;
  logic [ADDR_W-1:0] raddr1;
  logic [DATA_W-1:0] rdata1;
  logic              re2;
  logic [ADDR_W-1:0] raddr2;
  logic [DATA_W-1:0] rdata2;
  logic [DATA_W-1:0] hi_o;
  logic [DATA_W-1:0] lo_o;

  modport master (
    output wb_wd, wb_wreg, wb_wdata, wb_whilo, wb_hi, wb_lo,
    output re1, raddr1, re2, raddr2,
    input  rdata1, rdata2, hi_o, lo_o
  );

  modport slave (
    input  wb_wd, wb_wreg, wb_wdata, wb_whilo, wb_hi, wb_lo,
    input  re1, raddr1, re2, raddr2,
    output rdata1, rdata2, hi_o, lo_o
  );
endinterface : wb_regfile_if

// File: rtl/wb_regfile_hilo_reg.sv
// HI/LO pair storage, written together; 1-edge write, 0-cycle read via bypass.
// No backpressure: a write is taken every cycle i_we is high.
module hilo_reg
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W = RegBusW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic [DATA_W-1:0] i_hi,
  input  logic [DATA_W-1:0] i_lo,
  output logic [DATA_W-1:0] o_hi,
  output logic [DATA_W-1:0] o_lo
);
  logic [DATA_W-1:0] r_hi;
  logic [DATA_W-1:0] r_lo;

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (i_we == WriteEnable) begin
      r_hi <= i_hi;
      r_lo <= i_lo;
    end
  end

  always_comb begin
    o_hi = r_hi;
    o_lo = r_lo;
    if (rst == RstEnable) begin
      o_hi = '0;
      o_lo = '0;
    end else if (i_we == WriteEnable) begin
      o_hi = i_hi;
      o_lo = i_lo;
    end
  end
endmodule : hilo_reg

// File: rtl/wb_regfile.sv
// Architectural GPR file plus HI/LO; 1-edge write, same-cycle visibility through bypass.
// No backpressure: one GPR and one HI/LO write accepted per cycle unconditionally.
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W = RegBusW,
  parameter int ADDR_W = RegAddrBusW
) (
  input  logic         clk,
  input  logic         rst,
  wb_regfile_if.slave  bus
);
  localparam int NREGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_gpr [NREGS];
  logic [DATA_W-1:0] w_rdata1;
  logic [DATA_W-1:0] w_rdata2;
  logic [DATA_W-1:0] w_hi;
  logic [DATA_W-1:0] w_lo;

  // Entry 0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      for (int i = 0; i < NREGS; i++) begin
        r_gpr[i] <= '0;
      end
    end else if (bus.wb_wreg == WriteEnable && bus.wb_wd != NOPRegAddr) begin
      r_gpr[bus.wb_wd] <= bus.wb_wdata;
    end
  end

  function automatic logic [DATA_W-1:0] read_port(
    input logic              ren,
    input logic [ADDR_W-1:0] raddr,
    input logic [DATA_W-1:0] stored
  );
    if (rst == RstEnable)                                   return '0;
    if (ren == ReadDisable)                                 return '0;
    if (raddr == NOPRegAddr)                                return '0;
    if (bus.wb_wreg == WriteEnable && bus.wb_wd == raddr)   return bus.wb_wdata;
    return stored;
  endfunction

  always_comb begin
    w_rdata1 = read_port(bus.re1, bus.raddr1, r_gpr[bus.raddr1]);
    w_rdata2 = read_port(bus.re2, bus.raddr2, r_gpr[bus.raddr2]);
  end

  hilo_reg #(
    .DATA_W (DATA_W)
  ) u_hilo (
    .clk  (clk),
    .rst  (rst),
    .i_we (bus.wb_whilo),
    .i_hi (bus.wb_hi),
    .i_lo (bus.wb_lo),
    .o_hi (w_hi),
    .o_lo (w_lo)
  );

  assign bus.rdata1 = w_rdata1;
  assign bus.rdata2 = w_rdata2;
  assign bus.hi_o   = w_hi;
  assign bus.lo_o   = w_lo;
endmodule : wb_regfile

// File: tb/tb_wb_regfile.sv
// Directed vector table, a write-enable glitch sequence, then random traffic against a reference model.
module tb_wb_regfile;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  wb_regfile_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  wb_regfile #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        wreg;
    logic [4:0]  wd;
    logic [31:0] wdata;
    logic        whilo;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        re1;
    logic [4:0]  ra1;
    logic        re2;
    logic [4:0]  ra2;
    logic [31:0] e1;
    logic [31:0] e2;
    logic [31:0] ehi;
    logic [31:0] elo;
  } vec_t;

  vec_t vecs [19];

  logic [31:0] m_gpr [32];
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic wreg, input logic [4:0] wd, input logic [31:0] wdata,
                       input logic whilo, input logic [31:0] hi, input logic [31:0] lo,
                       input logic re1, input logic [4:0] ra1, input logic re2, input logic [4:0] ra2);
    rst          = r;
    bus.wb_wreg  = wreg;
    bus.wb_wd    = wd;
    bus.wb_wdata = wdata;
    bus.wb_whilo = whilo;
    bus.wb_hi    = hi;
    bus.wb_lo    = lo;
    bus.re1      = re1;
    bus.raddr1   = ra1;
    bus.re2      = re2;
    bus.raddr2   = ra2;
  endtask

  function automatic logic [31:0] model_read(input logic r, input logic ren, input logic [4:0] ra,
                                             input logic wreg, input logic [4:0] wd, input logic [31:0] wdata);
    if (!r || !ren || ra == 5'd0) return 32'h0;
    if (wreg && wd == ra)         return wdata;
    return m_gpr[ra];
  endfunction

  initial begin
    total = 0;
    bad   = 0;
    drive(1'b0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    //          rst wr  wd  wdata         hl  hi            lo            re1 ra1 re2 ra2  e1            e2            ehi           elo
    vecs[0]  = '{0, 0, 0,  32'h0,        0, 32'h0,        32'h0,        1, 5,  1, 7,  32'h0,        32'h0,        32'h0,        32'h0};
    vecs[1]  = '{1, 1, 5,  32'hDEADBEEF, 0, 32'h0,        32'h0,        1, 5,  0, 5,  32'hDEADBEEF, 32'h0,        32'h0,        32'h0};
    vecs[2]  = '{1, 0, 5,  32'h0,        0, 32'h0,        32'h0,        1, 5,  1, 5,  32'hDEADBEEF, 32'hDEADBEEF, 32'h0,        32'h0};
    vecs[3]  = '{0, 1, 5,  32'h11111111, 0, 32'h0,        32'h0,        1, 5,  1, 5,  32'h0,        32'h0,        32'h0,        32'h0};
    vecs[4]  = '{1, 0, 0,  32'h0,        0, 32'h0,        32'h0,        1, 5,  1, 5,  32'h0,        32'h0,        32'h0,        32'h0};
    vecs[5]  = '{1, 1, 7,  32'h12345678, 0, 32'h0,        32'h0,        0, 7,  1, 7,  32'h0,        32'h12345678, 32'h0,        32'h0};
    vecs[6]  = '{1, 0, 0,  32'h0,        0, 32'h0,        32'h0,        1, 7,  1, 7,  32'h12345678, 32'h12345678, 32'h0,        32'h0};
    vecs[7]  = '{1, 1, 3,  32'hA5A5A5A5, 0, 32'h0,        32'h0,        1, 3,  1, 3,  32'hA5A5A5A5, 32'hA5A5A5A5, 32'h0,        32'h0};
    vecs[8]  = '{1, 0, 0,  32'h0,        0, 32'h0,        32'h0,        1, 3,  1, 3,  32'hA5A5A5A5, 32'hA5A5A5A5, 32'h0,        32'h0};
    vecs[9]  = '{1, 1, 0,  32'hFFFFFFFF, 0, 32'h0,        32'h0,        1, 0,  1, 0,  32'h0,        32'h0,        32'h0,        32'h0};
    vecs[10] = '{1, 0, 0,  32'h0,        0, 32'h0,        32'h0,        1, 0,  1, 0,  32'h0,        32'h0,        32'h0,        32'h0};
    vecs[11] = '{1, 1, 9,  32'h55,       0, 32'h0,        32'h0,        1, 9,  1, 3,  32'h55,       32'hA5A5A5A5, 32'h0,        32'h0};
    vecs[12] = '{1, 0, 0,  32'h0,        0, 32'h0,        32'h0,        0, 9,  1, 9,  32'h0,        32'h55,       32'h0,        32'h0};
    vecs[13] = '{1, 0, 0,  32'h0,        1, 32'h1,        32'h2,        1, 9,  0, 0,  32'h55,       32'h0,        32'h1,        32'h2};
    vecs[14] = '{1, 0, 0,  32'h0,        0, 32'hAAAA,     32'hBBBB,     1, 7,  0, 0,  32'h12345678, 32'h0,        32'h1,        32'h2};
    vecs[15] = '{1, 0, 7,  32'hDEAD,     0, 32'h0,        32'h0,        1, 7,  1, 9,  32'h12345678, 32'h55,       32'h1,        32'h2};
    vecs[16] = '{1, 0, 0,  32'h0,        1, 32'hCAFE,     32'hF00D,     1, 3,  1, 7,  32'hA5A5A5A5, 32'h12345678, 32'hCAFE,     32'hF00D};
    vecs[17] = '{0, 0, 0,  32'h0,        1, 32'h9,        32'h9,        1, 3,  1, 7,  32'h0,        32'h0,        32'h0,        32'h0};
    vecs[18] = '{1, 0, 0,  32'h0,        0, 32'h0,        32'h0,        1, 3,  1, 7,  32'h0,        32'h0,        32'h0,        32'h0};

    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      drive(vecs[i].rst, vecs[i].wreg, vecs[i].wd, vecs[i].wdata, vecs[i].whilo, vecs[i].hi, vecs[i].lo,
            vecs[i].re1, vecs[i].ra1, vecs[i].re2, vecs[i].ra2);
      #2;
      check($sformatf("vec%0d.rdata1", i), bus.rdata1, vecs[i].e1);
      check($sformatf("vec%0d.rdata2", i), bus.rdata2, vecs[i].e2);
      check($sformatf("vec%0d.hi_o", i),   bus.hi_o,   vecs[i].ehi);
      check($sformatf("vec%0d.lo_o", i),   bus.lo_o,   vecs[i].elo);
    end

    // Write enable raised then dropped before the edge: bypass only, nothing stored.
    @(negedge clk);
    drive(1'b1, 1, 10, 32'h77, 0, 0, 0, 1, 10, 1, 10);
    #1;
    check("glitch.bypass", bus.rdata1, 32'h77);
    bus.wb_wreg = 1'b0;
    #1;
    check("glitch.dropped", bus.rdata2, 32'h0);
    @(negedge clk);
    #2;
    check("glitch.stored", bus.rdata1, 32'h0);

    // Async reset mid-cycle clears stored state without an edge.
    @(negedge clk);
    drive(1'b1, 1, 12, 32'hBEEF, 1, 32'h3, 32'h4, 1, 12, 0, 0);
    @(negedge clk);
    drive(1'b1, 0, 0, 0, 0, 0, 0, 1, 12, 0, 0);
    #1;
    check("async.before", bus.rdata1, 32'hBEEF);
    check("async.hi_before", bus.hi_o, 32'h3);
    rst = 1'b0;
    #1;
    check("async.during", bus.rdata1, 32'h0);
    rst = 1'b1;
    #1;
    check("async.after", bus.rdata1, 32'h0);
    check("async.hi_after", bus.hi_o, 32'h0);
    check("async.lo_after", bus.lo_o, 32'h0);

    for (int i = 0; i < 32; i++) m_gpr[i] = 32'h0;
    m_hi = 32'h0;
    m_lo = 32'h0;

    for (int n = 0; n < 2000; n++) begin
      logic        r;
      logic        wreg, whilo, re1, re2;
      logic [4:0]  wd, ra1, ra2;
      logic [31:0] wdata, hi, lo;
      @(negedge clk);
      r     = ($urandom_range(0, 39) != 0);
      wreg  = $urandom_range(0, 1);
      wd    = $urandom_range(0, 7);
      wdata = $urandom;
      whilo = ($urandom_range(0, 3) == 0);
      hi    = $urandom;
      lo    = $urandom;
      re1   = ($urandom_range(0, 7) != 0);
      re2   = ($urandom_range(0, 7) != 0);
      ra1   = $urandom_range(0, 7);
      ra2   = $urandom_range(0, 7);
      drive(r, wreg, wd, wdata, whilo, hi, lo, re1, ra1, re2, ra2);
      #2;
      check("rand.rdata1", bus.rdata1, model_read(r, re1, ra1, wreg, wd, wdata));
      check("rand.rdata2", bus.rdata2, model_read(r, re2, ra2, wreg, wd, wdata));
      check("rand.hi_o", bus.hi_o, !r ? 32'h0 : (whilo ? hi : m_hi));
      check("rand.lo_o", bus.lo_o, !r ? 32'h0 : (whilo ? lo : m_lo));
      if (!r) begin
        for (int i = 0; i < 32; i++) m_gpr[i] = 32'h0;
        m_hi = 32'h0;
        m_lo = 32'h0;
      end else begin
        if (wreg && wd != 5'd0) m_gpr[wd] = wdata;
        if (whilo) begin
          m_hi = hi;
          m_lo = lo;
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule : tb_wb_regfile

// File: doc/wb_regfile.md
# wb_regfile

Write-back end of the integer pipeline. The block receives the write stream leaving the MEM/WB pipeline register and holds the architectural state it updates: 32 general-purpose registers and the HI/LO pair. It serves two asynchronous GPR read ports and one HI/LO read port to ID/EX. Each read port bypasses a same-cycle write, so a value written in a cycle is visible to readers in that same cycle.

## Interface
Parameters:
- DATA_W, 32, register data width
- ADDR_W, 5, GPR address width; the file holds 2**ADDR_W entries

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-low reset
- wb_wd  in  ADDR_W  GPR write address
- wb_wreg  in  1  GPR write enable
- wb_wdata  in  DATA_W  GPR write data
- wb_whilo  in  1  HI/LO write enable
- wb_hi  in  DATA_W  HI write data
- wb_lo  in  DATA_W  LO write data
- re1  in  1  read port 1 enable
- raddr1  in  ADDR_W  read port 1 address
- rdata1  out  DATA_W  read port 1 data
- re2  in  1  read port 2 enable
- raddr2  in  ADDR_W  read port 2 address
- rdata2  out  DATA_W  read port 2 data
- hi_o  out  DATA_W  current HI, with bypass
- lo_o  out  DATA_W  current LO, with bypass

## Operation
- GPR write: on a rising clk edge with rst high, wb_wreg=1 and wb_wd!=0, the entry at wb_wd takes wb_wdata.
- Writes to address 0 are discarded. Entry 0 always reads 0.
- HI/LO write: on a rising edge with rst high and wb_whilo=1, HI takes wb_hi and LO takes wb_lo. HI and LO are always written as a pair.
- Read port n (n=1,2) is combinational. Checks apply in priority order:
  - rst low -> 0
  - ren=0 -> 0
  - raddrn=0 -> 0
  - wb_wreg=1 and wb_wd==raddrn -> wb_wdata (bypass)
  - otherwise -> the stored entry
- Both read ports may address the same register, or the write address, at the same time. Each port resolves independently.
- hi_o/lo_o are combinational:
  - rst low -> 0
  - wb_whilo=1 -> wb_hi/wb_lo (bypass)
  - otherwise -> the stored HI/LO
- There is no handshake and no stall. One write of each kind is accepted per cycle, unconditionally.

## Timing
- Write latency: 1 edge into storage. Effective read-visibility latency is 0 cycles via the bypass.
- Reset: asserting rst low clears all GPR entries, HI and LO to 0 immediately, without waiting for clk.
- While rst is low, every output reads 0 and all write enables are ignored.
- Reset asserted in the same cycle as a write: the write is lost.
- Deassertion of rst is synchronised externally. The first write takes effect on the first rising edge with rst high.
- Write enables are sampled only at the edge. A write-enable glitch between edges changes a read output only through the bypass path, never the stored state.

## Structure
- The shared package holds:
  - the RegBus/RegAddrBus widths
  - ZeroWord, NOPRegAddr
  - the WriteEnable/WriteDisable and ReadEnable/ReadDisable constants
  - the reset polarity constant RstEnable = 1'b0
- Sub-module hilo_reg: HI/LO storage, async reset and bypass, instanced once.
- The GPR array and the two read muxes live in the top level.

## Test plan
- Reset: drive rst low mid-run after writing 0xDEADBEEF to r5 -> rdata1 (re1=1, raddr1=5) reads 0 immediately. After release, r5 reads 0.
- Write then read: write 0x12345678 to r7, then read r7 on the following cycle via port 2 -> 0x12345678.
- Bypass: in one cycle write 0xA5A5A5A5 to r3 while raddr1=raddr2=3, re1=re2=1 -> both ports show 0xA5A5A5A5 in the same cycle, before the edge.
- r0: write 0xFFFFFFFF to r0, then read r0 on both ports -> 0. Bypass must not fire for address 0.
- Read disable: with re1=0 and r9 holding 0x55 -> rdata1=0, while rdata2 with re2=1, raddr2=9 reads 0x55.
- HI/LO: write hi=0x1, lo=0x2 with wb_whilo=1 -> hi_o/lo_o show 0x1/0x2 that same cycle and after the edge. A following cycle with wb_whilo=0 and different wb_hi/wb_lo values leaves 0x1/0x2 unchanged.
